datapath_load_ctrl: RTL and testbench

Hardware sequencer that brings up the datapath without a bench. It streams a data image into data memory and a program into instruction memory, then runs the core for a bounded cycle budget. It then streams data memory back to the host. It sits between the host/FIFO stream and the datapath's i_mem/d_mem load ports and pc_en.

---
 rtl/datapath_load_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_datapath_load_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_load_ctrl.sv
// datapath_load_ctrl
//   Bring-up sequencer for the datapath. It streams a data image into d_mem,
//   streams a program into i_mem, and runs the core for a bounded number of
//   cycles (or until halt). It then streams d_mem[1..N] back to the host.
//
//   Ports
//     clk, reset_n           clock (rising edge), async active-low reset
//     start                  one-cycle pulse, accepted in IDLE/DONE only
//     halt                   end-of-program flag, only looked at in RUN
//     s_valid/s_data/s_ready host input stream (header, N data, NUM_INSTR instr)
//     i_mem_*                instruction memory write port
//     d_mem_*                data memory port (write during load, read during readback)
//     d_mem_out              synchronous read data, valid 1 cycle after address
//     pc_en                  datapath run enable (high in every RUN cycle)
//     m_valid/m_data/m_ready host readback stream
//     busy/done              sequence status
//
//   Stream format: word 0 is the header. N = header saturated to 2^D_ADDR_W-1.
//   The raw header lands in d_mem[0], and words 1..N land in d_mem[1..N].
//   Then NUM_INSTR words follow, and the low 32 bits of each go to i_mem.
module datapath_load_ctrl #(
    parameter int NUM_INSTR  = 32,
    parameter int RUN_CYCLES = 2100,
    parameter int D_ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                halt,
    input  logic                s_valid,
    input  logic [63:0]         s_data,
    output logic                s_ready,
    output logic [31:0]         i_mem_addra,
    output logic [31:0]         i_mem_din,
    output logic                i_mem_we,
    output logic [D_ADDR_W-1:0] d_mem_addra,
    output logic [63:0]         d_mem_din,
    output logic                d_mem_we,
    input  logic [63:0]         d_mem_out,
    output logic                pc_en,
    output logic                m_valid,
    output logic [63:0]         m_data,
    input  logic                m_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [D_ADDR_W-1:0] N_MAX = '1;
    // k indexes both the data image (up to N_MAX, must not wrap) and the
    // program (up to NUM_INSTR-1); size it for whichever is larger.
    localparam int K_W  = (D_ADDR_W + 1 > $clog2(NUM_INSTR + 1)) ? D_ADDR_W + 1
                                                                 : $clog2(NUM_INSTR + 1);
    localparam int RC_W = $clog2(RUN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_DATA,
        LOAD_INSTR,
        RUN,
        RD_ADDR,
        RD_WAIT,
        RD_OUT,
        DONE
    } state_t;

    state_t              state;
    logic [K_W-1:0]      k;
    logic [D_ADDR_W-1:0] n_reg;
    logic [RC_W-1:0]     run_cnt;

    logic                xfer;
    logic [D_ADDR_W-1:0] hdr_sat;
    logic                last_data;
    logic                in_rd;

    // Header saturation: any set bit above the address width clamps N to N_MAX.
    assign hdr_sat = (|s_data[63:D_ADDR_W]) ? N_MAX : s_data[D_ADDR_W-1:0];

    // The final data word is the header itself when N=0, otherwise the word at k=N.
    assign last_data = (k == '0) ? (hdr_sat == '0) : (k == K_W'(n_reg));

    // Write ports are driven combinationally so that a word is written in
    // the same cycle it is accepted. Data buses are zeroed outside their load
    // state so that nothing reflects s_data while idle or in reset.
    assign s_ready     = (state == LOAD_DATA) || (state == LOAD_INSTR);
    assign xfer        = s_valid && s_ready;
    assign in_rd       = (state == RD_ADDR) || (state == RD_WAIT) || (state == RD_OUT);

    assign d_mem_we    = xfer && (state == LOAD_DATA);
    assign d_mem_din   = (state == LOAD_DATA) ? s_data : '0;
    assign d_mem_addra = ((state == LOAD_DATA) || in_rd) ? k[D_ADDR_W-1:0] : '0;

    assign i_mem_we    = xfer && (state == LOAD_INSTR);
    assign i_mem_din   = (state == LOAD_INSTR) ? s_data[31:0] : '0;
    assign i_mem_addra = (state == LOAD_INSTR) ? 32'(k) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            k       <= '0;
            n_reg   <= '0;
            run_cnt <= '0;
            pc_en   <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD_DATA;
                        k     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end

                LOAD_DATA: begin
                    if (xfer) begin
                        if (k == '0)
                            n_reg <= hdr_sat;
                        if (last_data) begin
                            state <= LOAD_INSTR;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end

                LOAD_INSTR: begin
                    if (xfer) begin
                        if (k == K_W'(NUM_INSTR - 1)) begin
                            state   <= RUN;
                            run_cnt <= '0;
                            pc_en   <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end

                RUN: begin
                    // halt sampled here ends RUN at this edge, so the run
                    // lasts (halt cycle index + 1) cycles.
                    if (halt || (run_cnt == RC_W'(RUN_CYCLES - 1))) begin
                        pc_en <= 1'b0;
                        if (n_reg == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RD_ADDR;
                            k     <= K_W'(1);
                        end
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end

                RD_ADDR: state <= RD_WAIT;

                // Address was presented in RD_ADDR, so read data is valid now.
                RD_WAIT: begin
                    m_data  <= d_mem_out;
                    m_valid <= 1'b1;
                    state   <= RD_OUT;
                end

                RD_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (k == K_W'(n_reg)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RD_ADDR;
                            k     <= k + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_load_ctrl.sv
// Testbench for datapath_load_ctrl: memory models behind the write/read ports,
// a table of sequences (header, halt point, backpressure, abort), and expected
// results computed from the stream format rules.
module tb_datapath_load_ctrl;

    localparam int NUM_INSTR  = 32;
    localparam int RUN_CYCLES = 2100;
    localparam int D_ADDR_W   = 8;
    localparam int N_MAX      = (1 << D_ADDR_W) - 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                start, halt, s_valid, m_ready;
    logic [63:0]         s_data;
    logic                s_ready, i_mem_we, d_mem_we, pc_en, m_valid, busy, done;
    logic [31:0]         i_mem_addra, i_mem_din;
    logic [D_ADDR_W-1:0] d_mem_addra;
    logic [63:0]         d_mem_din, d_mem_out, m_data;

    always #5 clk = ~clk;

    datapath_load_ctrl #(
        .NUM_INSTR(NUM_INSTR), .RUN_CYCLES(RUN_CYCLES), .D_ADDR_W(D_ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .i_mem_addra(i_mem_addra), .i_mem_din(i_mem_din), .i_mem_we(i_mem_we),
        .d_mem_addra(d_mem_addra), .d_mem_din(d_mem_din), .d_mem_we(d_mem_we),
        .d_mem_out(d_mem_out), .pc_en(pc_en),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    // Memory models: synchronous-read d_mem, write-only i_mem, with write counters.
    logic [63:0] dmem [0:N_MAX];
    logic [31:0] imem [0:NUM_INSTR-1];
    logic [63:0] d_rd = '0;
    int dw_cnt = 0, iw_cnt = 0, bad_iaddr = 0;

    always @(posedge clk) begin
        d_rd <= dmem[d_mem_addra];
        if (d_mem_we) begin
            dmem[d_mem_addra] <= d_mem_din;
            dw_cnt <= dw_cnt + 1;
        end
        if (i_mem_we) begin
            if (i_mem_addra < NUM_INSTR) imem[i_mem_addra[4:0]] <= i_mem_din;
            else bad_iaddr <= bad_iaddr + 1;
            iw_cnt <= iw_cnt + 1;
        end
    end
    assign d_mem_out = d_rd;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({s_ready, i_mem_we, d_mem_we, pc_en, m_valid, busy, done}), 64'd0);
        check({tag, "_addr"}, 64'({i_mem_addra, d_mem_addra}), 64'd0);
        check({tag, "_ddin"}, d_mem_din, 64'd0);
        check({tag, "_idin"}, 64'(i_mem_din), 64'd0);
        check({tag, "_mdata"}, m_data, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [63:0] header;
        int          halt_at;     // RUN cycle index where halt is driven, -1 = never
        bit          rand_traffic; // random s_valid gaps and stray halt/m_ready
        int          stall;       // cycles m_ready held low on each readback word
        bit          fixed;       // use the fixed 0x11.. data / 0x13+k program
        int          abort_at;    // reset after this many instr words, -1 = no abort
        int          exp_n;
        int          exp_pc;
    } vec_t;

    logic [63:0] fixed_d [3] = '{64'h11, 64'h22, 64'h33};

    task automatic run_flow(input vec_t v);
        logic [63:0] words[$];
        logic [63:0] exp_rd[$];
        logic [31:0] exp_i[$];
        logic [63:0] got[$];
        logic [63:0] w, prev_data;
        logic [31:0] iw;
        int n, dw0, iw0, nx, cyc, pc, stall_cnt, stable_err;
        bit xfer, prev_hold;

        // Reference: N is the header clamped to the largest d_mem address.
        n = (v.header > 64'(N_MAX)) ? N_MAX : int'(v.header);
        words.push_back(v.header);
        for (int i = 1; i <= n; i++) begin
            w = v.fixed ? fixed_d[i-1] : {$urandom, $urandom};
            words.push_back(w);
            exp_rd.push_back(w);
        end
        for (int i = 0; i < NUM_INSTR; i++) begin
            iw = v.fixed ? 32'h13 + 32'(i) : $urandom;
            words.push_back({$urandom, iw});
            exp_i.push_back(iw);
        end
        dw0 = dw_cnt;
        iw0 = iw_cnt;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({v.name, "_busy_start"}, 64'(busy), 64'd1);

        // Load phase
        nx = 0; cyc = 0;
        while (words.size() > 0 && cyc < 20000) begin
            if (v.abort_at >= 0 && nx == n + 1 + v.abort_at) begin
                check({v.name, "_pre_abort_sready"}, 64'(s_ready), 64'd1);
                #2 reset_n = 1'b0;
                #1 check_reset_outputs({v.name, "_abort"});
                s_valid = 1'b0;
                @(negedge clk); @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                check({v.name, "_idle_after_abort"}, 64'({busy, done, s_ready}), 64'd0);
                return;
            end
            s_valid = v.rand_traffic ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = s_valid ? words[0] : {$urandom, $urandom};
            halt    = v.rand_traffic ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer    = s_valid && s_ready;
            @(posedge clk);
            if (xfer) begin
                void'(words.pop_front());
                nx++;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        halt    = 1'b0;
        if (words.size() > 0) check({v.name, "_load_timeout"}, 64'(words.size()), 64'd0);

        // Run phase: count pc_en cycles, raise halt in the chosen cycle.
        pc = 0; cyc = 0;
        while (cyc < RUN_CYCLES + 50) begin
            if (!pc_en) break;
            halt = (pc == v.halt_at);
            pc++;
            @(negedge clk);
            cyc++;
        end
        halt = 1'b0;
        check({v.name, "_pc_en_cycles"}, 64'(pc), 64'(v.exp_pc));

        // Readback phase
        stall_cnt = 0; stable_err = 0; prev_hold = 1'b0; prev_data = '0; cyc = 0;
        while (!done && cyc < 10000) begin
            if (prev_hold && m_valid && m_data !== prev_data) stable_err++;
            halt = v.rand_traffic ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_valid) begin
                if (stall_cnt < v.stall) begin
                    m_ready = 1'b0;
                    stall_cnt++;
                    prev_hold = 1'b1;
                    prev_data = m_data;
                end else begin
                    m_ready = 1'b1;
                    got.push_back(m_data);
                    stall_cnt = 0;
                    prev_hold = 1'b0;
                end
            end else begin
                m_ready = v.rand_traffic ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_hold = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        halt    = 1'b0;

        check({v.name, "_done"}, 64'({done, busy}), 64'b10);
        check({v.name, "_m_valid_idle"}, 64'(m_valid), 64'd0);
        check({v.name, "_rd_count"}, 64'(got.size()), 64'(v.exp_n));
        check({v.name, "_stable"}, 64'(stable_err), 64'd0);
        for (int i = 0; i < got.size() && i < exp_rd.size(); i++)
            check({v.name, "_rd_data"}, got[i], exp_rd[i]);
        check({v.name, "_d_writes"}, 64'(dw_cnt - dw0), 64'(v.exp_n + 1));
        check({v.name, "_i_writes"}, 64'(iw_cnt - iw0), 64'(NUM_INSTR));
        check({v.name, "_bad_iaddr"}, 64'(bad_iaddr), 64'd0);
        check({v.name, "_dmem_hdr"}, dmem[0], v.header);
        for (int i = 1; i <= n; i++)
            check({v.name, "_dmem"}, dmem[i], exp_rd[i-1]);
        for (int i = 0; i < NUM_INSTR; i++)
            check({v.name, "_imem"}, 64'(imem[i]), 64'(exp_i[i]));
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"full",       64'd3,                  -1,             0, 0, 1, -1, 3,   RUN_CYCLES};
        vecs[1] = '{"backpress",  64'd6,                  100,            1, 5, 0, -1, 6,   101};
        vecs[2] = '{"early_halt", 64'd4,                  40,             0, 0, 0, -1, 4,   41};
        vecs[3] = '{"n_zero",     64'd0,                  -1,             1, 0, 0, -1, 0,   RUN_CYCLES};
        vecs[4] = '{"sat_1ff",    64'h1FF,                10,             1, 1, 0, -1, 255, 11};
        vecs[5] = '{"sat_big",    64'hFFFF_0000_0000_0005, 0,             0, 0, 0, -1, 255, 1};
        vecs[6] = '{"halt_last",  64'd2,                  RUN_CYCLES - 1, 0, 2, 0, -1, 2,   RUN_CYCLES};
        vecs[7] = '{"abort",      64'd2,                  -1,             0, 0, 0, 10, 2,   0};
        vecs[8] = '{"restart",    64'd3,                  -1,             0, 0, 1, -1, 3,   RUN_CYCLES};

        reset_n = 1'b0; start = 1'b0; halt = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;

        // Reset with random inputs, including start pulses.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            halt    = 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = {$urandom, $urandom};
            #1 check_reset_outputs("reset");
        end
        @(negedge clk);
        start = 1'b0; halt = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("start_in_reset_ignored", 64'({busy, done, s_ready, pc_en}), 64'd0);

        for (int i = 0; i < 9; i++) run_flow(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
